mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV64M multiply/divide unit that accompanies the single-cycle ALU in the execute stage.
//  Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants, one result bit per cycle.
//  Uses a valid/ready handshake; the control unit stalls the pipeline while o_ready is low.
// PARAMETERS
//  DATA_WIDTH    64  operand/result width (XLEN); must be even and >= 8
//  WORD_WIDTH    32  width of W-variant operations; must be <= DATA_WIDTH
//  CONTROL_WIDTH 4   width of i_op
// PORTS
//  clk          in   1              clock, all state updates on rising edge
//  arst         in   1              asynchronous active-high reset
//  i_valid      in   1              request valid
//  o_ready      out  1              unit can accept a request (state IDLE)
//  i_op         in   CONTROL_WIDTH  operation select, encoding below
//  i_src_1      in   DATA_WIDTH     rs1 operand (multiplicand / dividend)
//  i_src_2      in   DATA_WIDTH     rs2 operand (multiplier / divisor)
//  i_flush      in   1              abort the in-flight operation
//  o_valid      out  1              o_result valid (state DONE)
//  i_ready      in   1              consumer accepts the result
//  o_result     out  DATA_WIDTH     result, held stable while o_valid=1
// BEHAVIOUR
//  Reset: async on arst=1; state=IDLE, o_ready=1, o_valid=0, o_result=0, counter=0.
//  Ops: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW,
//       10 DIVUW, 11 REMW, 12 REMUW. Codes 13-15 are illegal: DONE next cycle, result 0.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: when i_valid & o_ready, latch op and operands, go to CALC (or straight to DONE for
//     special cases). o_ready=1 only in IDLE.
//   CALC: run N = DATA_WIDTH iterations (N = WORD_WIDTH for W ops), one per cycle, then go to DONE.
//     o_valid is first high N+1 cycles after the accept edge.
//   DONE: o_valid=1 until i_valid_ack (i_ready=1) is sampled, then go to IDLE.
//     The next request is accepted at the earliest one cycle later. No back-to-back bypass.
//  Operands and arithmetic:
//   - W ops use bits [WORD_WIDTH-1:0] of each source.
//   - Signed ops use |operand|; the result sign is fixed up at the CALC->DONE transition.
//   - Multiply: shift-add into a 2*N-bit product.
//     MUL/MULW return the low N bits; MULH/MULHSU/MULHU return the high N bits.
//     For MULHSU, src_1 is signed and src_2 is unsigned.
//   - Divide: restoring shift-subtract producing an N-bit quotient and remainder.
//     Remainder sign follows the dividend; quotient truncates toward zero.
//   - W results are sign-extended from bit WORD_WIDTH-1 to DATA_WIDTH, including DIVUW/REMUW.
//  Special cases resolve in 1 cycle: IDLE -> DONE, with o_valid high 1 cycle after accept.
//   - Divisor==0: quotient = all ones (W: sign-extended all ones); remainder = dividend.
//   - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
//  i_flush: in CALC or DONE, return to IDLE next cycle with o_valid=0 and no result delivered.
//   In IDLE, flush overrides i_valid: the request is not accepted.
//  arst mid-operation: immediate return to IDLE, outputs at reset values.
//  o_result updates only on entry to DONE; inputs are not sampled outside the IDLE accept.
// TESTING
//  1. MUL 7 x -3 (64b): o_valid at cycle 65 -> o_result=0xFFFF_FFFF_FFFF_FFEB; MULHU 2^63 x 4 -> 2.
//  2. MULH -1 x -1 -> 0; MULHSU -1 x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF; MULW 0x8000_0000 x 1 -> 0xFFFF_FFFF_8000_0000.
//  3. DIV -7/2 -> -3, REM -7/2 -> -1; DIVU 100/7 -> 14; REMUW 0xFFFF_FFFF/1 -> 0; DIVW result at cycle 33.
//  4. DIV 5/0 -> all ones and REM 5/0 -> 5; DIV 0x8000_0000_0000_0000/-1 -> same value, REM -> 0; each o_valid 1 cycle after accept.
//  5. Hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready=0; new i_valid ignored until return to IDLE.
//  6. Flush at CALC cycle 20 and again in DONE; arst at CALC cycle 30 -> IDLE, o_ready=1, o_valid=0; next request computes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Signed operands are reduced to magnitudes on accept; the sign is restored when CALC hands off to DONE.
module mul_div_unit #(
   parameter int DATA_WIDTH    = 64,
   parameter int WORD_WIDTH    = 32,
   parameter int CONTROL_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [CONTROL_WIDTH-1:0] i_op,
   input  logic [DATA_WIDTH-1:0]    i_src_1,
   input  logic [DATA_WIDTH-1:0]    i_src_2,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_WIDTH-1:0]    o_result
);

   localparam int CW      = $clog2(DATA_WIDTH + 1);
   localparam int PW      = 2 * DATA_WIDTH;
   localparam int W_SHIFT = DATA_WIDTH - WORD_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CONTROL_WIDTH-1:0] OP_MUL    = CONTROL_WIDTH'(0);
   localparam logic [CONTROL_WIDTH-1:0] OP_MULH   = CONTROL_WIDTH'(1);
   localparam logic [CONTROL_WIDTH-1:0] OP_MULHSU = CONTROL_WIDTH'(2);
   localparam logic [CONTROL_WIDTH-1:0] OP_MULHU  = CONTROL_WIDTH'(3);
   localparam logic [CONTROL_WIDTH-1:0] OP_DIV    = CONTROL_WIDTH'(4);
   localparam logic [CONTROL_WIDTH-1:0] OP_DIVU   = CONTROL_WIDTH'(5);
   localparam logic [CONTROL_WIDTH-1:0] OP_REM    = CONTROL_WIDTH'(6);
   localparam logic [CONTROL_WIDTH-1:0] OP_REMU   = CONTROL_WIDTH'(7);
   localparam logic [CONTROL_WIDTH-1:0] OP_MULW   = CONTROL_WIDTH'(8);
   localparam logic [CONTROL_WIDTH-1:0] OP_DIVW   = CONTROL_WIDTH'(9);
   localparam logic [CONTROL_WIDTH-1:0] OP_DIVUW  = CONTROL_WIDTH'(10);
   localparam logic [CONTROL_WIDTH-1:0] OP_REMW   = CONTROL_WIDTH'(11);
   localparam logic [CONTROL_WIDTH-1:0] OP_REMUW  = CONTROL_WIDTH'(12);

   logic [1:0]            r_state;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_isMul;
   logic                  r_isW;
   logic                  r_wantHigh;
   logic                  r_wantRem;
   logic                  r_negRes;
   logic                  r_negRem;
   logic [PW-1:0]         r_acc;
   logic [PW-1:0]         r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_divisor;

   logic                  w_isMul;
   logic                  w_isW;
   logic                  w_signA;
   logic                  w_signB;
   logic                  w_wantHigh;
   logic                  w_wantRem;
   logic                  w_illegal;

   always_comb begin
      w_isMul    = 1'b0;
      w_isW      = 1'b0;
      w_signA    = 1'b0;
      w_signB    = 1'b0;
      w_wantHigh = 1'b0;
      w_wantRem  = 1'b0;
      w_illegal  = 1'b0;
      case (i_op)
         OP_MUL:    w_isMul = 1'b1;
         OP_MULH:   begin w_isMul = 1'b1; w_signA = 1'b1; w_signB = 1'b1; w_wantHigh = 1'b1; end
         OP_MULHSU: begin w_isMul = 1'b1; w_signA = 1'b1; w_wantHigh = 1'b1; end
         OP_MULHU:  begin w_isMul = 1'b1; w_wantHigh = 1'b1; end
         OP_DIV:    begin w_signA = 1'b1; w_signB = 1'b1; end
         OP_DIVU:   ;
         OP_REM:    begin w_signA = 1'b1; w_signB = 1'b1; w_wantRem = 1'b1; end
         OP_REMU:   w_wantRem = 1'b1;
         OP_MULW:   begin w_isMul = 1'b1; w_isW = 1'b1; end
         OP_DIVW:   begin w_isW = 1'b1; w_signA = 1'b1; w_signB = 1'b1; end
         OP_DIVUW:  w_isW = 1'b1;
         OP_REMW:   begin w_isW = 1'b1; w_signA = 1'b1; w_signB = 1'b1; w_wantRem = 1'b1; end
         OP_REMUW:  begin w_isW = 1'b1; w_wantRem = 1'b1; end
         default:   w_illegal = 1'b1;
      endcase
   end

   logic [DATA_WIDTH-1:0] w_srcAExt;
   logic [DATA_WIDTH-1:0] w_srcBExt;
   logic [DATA_WIDTH-1:0] w_opA;
   logic [DATA_WIDTH-1:0] w_opB;
   logic                  w_negA;
   logic                  w_negB;
   logic [DATA_WIDTH-1:0] w_absA;
   logic [DATA_WIDTH-1:0] w_absB;
   logic [DATA_WIDTH-1:0] w_minNeg;
   logic                  w_divZero;
   logic                  w_overflow;
   logic [DATA_WIDTH-1:0] w_specialResult;

   // W ops see their operands as N-bit values extended to full width before taking magnitudes.
   assign w_srcAExt = DATA_WIDTH'($signed(i_src_1[WORD_WIDTH-1:0]));
   assign w_srcBExt = DATA_WIDTH'($signed(i_src_2[WORD_WIDTH-1:0]));
   assign w_opA     = w_isW ? (w_signA ? w_srcAExt : DATA_WIDTH'(i_src_1[WORD_WIDTH-1:0])) : i_src_1;
   assign w_opB     = w_isW ? (w_signB ? w_srcBExt : DATA_WIDTH'(i_src_2[WORD_WIDTH-1:0])) : i_src_2;
   assign w_negA    = w_signA & w_opA[DATA_WIDTH-1];
   assign w_negB    = w_signB & w_opB[DATA_WIDTH-1];
   assign w_absA    = w_negA ? -w_opA : w_opA;
   assign w_absB    = w_negB ? -w_opB : w_opB;
   assign w_minNeg  = w_isW ? DATA_WIDTH'($signed({1'b1, {(WORD_WIDTH-1){1'b0}}}))
                            : {1'b1, {(DATA_WIDTH-1){1'b0}}};

   assign w_divZero  = ~w_isMul & ~w_illegal & (w_opB == '0);
   assign w_overflow = ~w_isMul & ~w_illegal & w_signA & (w_opA == w_minNeg) & (w_opB == '1);

   always_comb begin
      w_specialResult = '0;
      if (w_divZero)
         w_specialResult = w_wantRem ? (w_isW ? w_srcAExt : i_src_1) : '1;
      else if (w_overflow)
         w_specialResult = w_wantRem ? '0 : w_opA;
   end

   logic [CW-1:0]         w_iterLimit;
   logic [DATA_WIDTH:0]   w_remShift;
   logic [DATA_WIDTH:0]   w_remDiff;
   logic [PW-1:0]         w_prodFix;
   logic [DATA_WIDTH-1:0] w_quoFix;
   logic [DATA_WIDTH-1:0] w_remFix;
   logic [DATA_WIDTH-1:0] w_mulRes;
   logic [DATA_WIDTH-1:0] w_divSel;
   logic [DATA_WIDTH-1:0] w_divRes;
   logic [DATA_WIDTH-1:0] w_finalResult;

   assign w_iterLimit = r_isW ? CW'(WORD_WIDTH) : CW'(DATA_WIDTH);
   assign w_remShift  = {r_rem, r_quo[DATA_WIDTH-1]};
   assign w_remDiff   = w_remShift - {1'b0, r_divisor};

   // Sign restoration and result selection applied on the CALC -> DONE edge.
   assign w_prodFix     = r_negRes ? -r_acc : r_acc;
   assign w_quoFix      = r_negRes ? -r_quo : r_quo;
   assign w_remFix      = r_negRem ? -r_rem : r_rem;
   assign w_mulRes      = r_isW      ? DATA_WIDTH'($signed(w_prodFix[WORD_WIDTH-1:0])) :
                          r_wantHigh ? w_prodFix[PW-1:DATA_WIDTH] : w_prodFix[DATA_WIDTH-1:0];
   assign w_divSel      = r_wantRem ? w_remFix : w_quoFix;
   assign w_divRes      = r_isW ? DATA_WIDTH'($signed(w_divSel[WORD_WIDTH-1:0])) : w_divSel;
   assign w_finalResult = r_isMul ? w_mulRes : w_divRes;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_result   <= '0;
         r_isMul    <= 1'b0;
         r_isW      <= 1'b0;
         r_wantHigh <= 1'b0;
         r_wantRem  <= 1'b0;
         r_negRes   <= 1'b0;
         r_negRem   <= 1'b0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_divisor  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid && !i_flush) begin
                  r_isMul    <= w_isMul;
                  r_isW      <= w_isW;
                  r_wantHigh <= w_wantHigh;
                  r_wantRem  <= w_wantRem;
                  r_negRes   <= w_negA ^ w_negB;
                  r_negRem   <= w_negA;
                  r_count    <= '0;
                  r_acc      <= '0;
                  r_mcand    <= PW'(w_absA);
                  r_mplier   <= w_absB;
                  r_rem      <= '0;
                  // Left-align a W dividend so the restoring loop consumes its top bit first.
                  r_quo      <= w_isW ? (w_absA << W_SHIFT) : w_absA;
                  r_divisor  <= w_absB;
                  if (w_illegal) begin
                     r_result <= '0;
                     r_state  <= S_DONE;
                  end else if (w_divZero || w_overflow) begin
                     r_result <= w_specialResult;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (i_flush) begin
                  r_state <= S_IDLE;
                  r_count <= '0;
               end else if (r_count == w_iterLimit) begin
                  r_result <= w_finalResult;
                  r_state  <= S_DONE;
                  r_count  <= '0;
               end else begin
                  r_count <= r_count + CW'(1);
                  if (r_isMul) begin
                     if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                     r_mcand  <= r_mcand << 1;
                     r_mplier <= r_mplier >> 1;
                  end else if (!w_remDiff[DATA_WIDTH]) begin
                     r_rem <= w_remDiff[DATA_WIDTH-1:0];
                     r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
                  end else begin
                     r_rem <= w_remShift[DATA_WIDTH-1:0];
                     r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
            S_DONE: begin
               if (i_flush || i_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign o_result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed checks of the documented cases plus randomized
// operations compared against a plain-arithmetic model of the RV64M instruction semantics.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        arst;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_op;
   logic [63:0] i_src_1;
   logic [63:0] i_src_2;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_result;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      logic [7:0]  lat;
   } vec_t;

   mul_div_unit #(
      .DATA_WIDTH(64),
      .WORD_WIDTH(32),
      .CONTROL_WIDTH(4)
   ) dut (
      .clk(clk),
      .arst(arst),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_op(i_op),
      .i_src_1(i_src_1),
      .i_src_2(i_src_2),
      .i_flush(i_flush),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_result(o_result)
   );

   always #5 clk = ~clk;

   // Instruction-level reference: what RV64M says each op returns.
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] ps;
      logic [127:0]        pu;
      logic signed [63:0]  sa;
      logic signed [63:0]  sb;
      logic signed [31:0]  sa32;
      logic signed [31:0]  sb32;
      logic [31:0]         a32;
      logic [31:0]         b32;
      logic [31:0]         t;
      logic [63:0]         r;
      sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      r = '0; t = '0;
      case (op)
         4'd0: r = a * b;
         4'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
         4'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = ps[127:64]; end
         4'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
         4'd4: begin
            if (b == 64'd0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
            else r = sa / sb;
         end
         4'd5: begin if (b == 64'd0) r = '1; else r = a / b; end
         4'd6: begin
            if (b == 64'd0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
            else r = sa % sb;
         end
         4'd7: begin if (b == 64'd0) r = a; else r = a % b; end
         4'd8: begin t = a32 * b32; r = {{32{t[31]}}, t}; end
         4'd9: begin
            if (b32 == 32'd0) t = '1;
            else if (a32 == 32'h8000_0000 && b32 == '1) t = a32;
            else t = sa32 / sb32;
            r = {{32{t[31]}}, t};
         end
         4'd10: begin
            if (b32 == 32'd0) t = '1; else t = a32 / b32;
            r = {{32{t[31]}}, t};
         end
         4'd11: begin
            if (b32 == 32'd0) t = a32;
            else if (a32 == 32'h8000_0000 && b32 == '1) t = '0;
            else t = sa32 % sb32;
            r = {{32{t[31]}}, t};
         end
         4'd12: begin
            if (b32 == 32'd0) t = a32; else t = a32 % b32;
            r = {{32{t[31]}}, t};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Cycles from accept edge to first o_valid: 1 for shortcut cases, else width+1.
   function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      if (op > 4'd12) return 1;
      if (op >= 4'd4 && op <= 4'd7) begin
         if (b == 64'd0) return 1;
         if ((op == 4'd4 || op == 4'd6) && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
         return 65;
      end
      if (op >= 4'd9) begin
         if (b[31:0] == 32'd0) return 1;
         if ((op == 4'd9 || op == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
         return 33;
      end
      if (op == 4'd8) return 33;
      return 65;
   endfunction

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'hFFFF_FFFF_8000_0000;
         4:       return 64'($urandom_range(0, 20));
         5:       return {32'd0, 32'($urandom())};
         default: return {32'($urandom()), 32'($urandom())};
      endcase
   endfunction

   // Issues one request from IDLE and waits (bounded) for o_valid; lat=-1 if it never came.
   task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      i_op = op; i_src_1 = a; i_src_2 = b; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge clk); #1;
         lat++;
         if (o_valid) seen = 1'b1;
      end
      if (!seen) lat = -1;
      res = o_result;
   endtask

   task automatic ack();
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
      i_op = '0; i_src_1 = '0; i_src_2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h want=0", o_result); end
      arst = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got=%b want=1", o_ready); end
   endtask

   task automatic test_multiply();
      vec_t        tbl [5];
      logic [63:0] res;
      int          lat;
      tbl[0] = '{4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 8'd65};
      tbl[1] = '{4'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 8'd65};
      tbl[2] = '{4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd65};
      tbl[3] = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65};
      tbl[4] = '{4'd8, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 8'd33};
      for (int i = 0; i < 5; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
         checks++; if (res !== tbl[i].exp) begin failures++; $display("FAIL mul_result[%0d] got=%h want=%h", i, res, tbl[i].exp); end
         checks++; if (lat !== int'(tbl[i].lat)) begin failures++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, tbl[i].lat); end
         ack();
      end
   endtask

   task automatic test_divide();
      vec_t        tbl [5];
      logic [63:0] res;
      int          lat;
      tbl[0] = '{4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65};
      tbl[1] = '{4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65};
      tbl[2] = '{4'd5, 64'd100, 64'd7, 64'd14, 8'd65};
      tbl[3] = '{4'd12, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 8'd33};
      tbl[4] = '{4'd9, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 8'd33};
      for (int i = 0; i < 5; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
         checks++; if (res !== tbl[i].exp) begin failures++; $display("FAIL div_result[%0d] got=%h want=%h", i, res, tbl[i].exp); end
         checks++; if (lat !== int'(tbl[i].lat)) begin failures++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, tbl[i].lat); end
         ack();
      end
   endtask

   task automatic test_special();
      vec_t        tbl [8];
      logic [63:0] res;
      int          lat;
      tbl[0] = '{4'd4, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
      tbl[1] = '{4'd6, 64'd5, 64'd0, 64'd5, 8'd1};
      tbl[2] = '{4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd1};
      tbl[3] = '{4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd1};
      tbl[4] = '{4'd9, 64'd7, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
      tbl[5] = '{4'd12, 64'h1234_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 8'd1};
      tbl[6] = '{4'd9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1};
      tbl[7] = '{4'd13, 64'd9, 64'd3, 64'd0, 8'd1};
      for (int i = 0; i < 8; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
         checks++; if (res !== tbl[i].exp) begin failures++; $display("FAIL special_result[%0d] got=%h want=%h", i, res, tbl[i].exp); end
         checks++; if (lat !== int'(tbl[i].lat)) begin failures++; $display("FAIL special_latency[%0d] got=%0d want=%0d", i, lat, tbl[i].lat); end
         ack();
      end
   endtask

   task automatic test_hold();
      logic [63:0] res;
      int          lat;
      do_op(4'd5, 64'd100, 64'd7, res, lat);
      checks++; if (res !== 64'd14) begin failures++; $display("FAIL hold_result got=%h want=%h", res, 64'd14); end
      i_valid = 1'b1; i_op = 4'd0; i_src_1 = 64'd3; i_src_2 = 64'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b want=1", c, o_valid); end
         checks++; if (o_result !== 64'd14) begin failures++; $display("FAIL hold_stable[%0d] got=%h want=%h", c, o_result, 64'd14); end
         checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d] got=%b want=0", c, o_ready); end
      end
      i_valid = 1'b0;
      ack();
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b want=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b want=0", o_valid); end
      do_op(4'd0, 64'd6, 64'd7, res, lat);
      checks++; if (res !== 64'd42) begin failures++; $display("FAIL hold_next_result got=%h want=%h", res, 64'd42); end
      ack();
   endtask

   task automatic test_flush();
      logic [63:0] res;
      int          lat;
      int          sawValid;
      i_op = 4'd0; i_src_1 = 64'd123; i_src_2 = 64'd456; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_calc_ready got=%b want=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_calc_valid got=%b want=0", o_valid); end
      sawValid = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (o_valid) sawValid++;
      end
      checks++; if (sawValid !== 0) begin failures++; $display("FAIL flush_calc_no_result got=%0d want=0", sawValid); end

      do_op(4'd0, 64'd3, 64'd5, res, lat);
      checks++; if (res !== 64'd15) begin failures++; $display("FAIL flush_done_pre got=%h want=%h", res, 64'd15); end
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_done_valid got=%b want=0", o_valid); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_done_ready got=%b want=1", o_ready); end

      i_op = 4'd13; i_valid = 1'b1; i_flush = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_ready got=%b want=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_valid got=%b want=0", o_valid); end

      do_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat);
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL flush_after_result got=%h want=%h", res, 64'hFFFF_FFFF_FFFF_FFFD); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL flush_after_latency got=%0d want=65", lat); end
      ack();
   endtask

   task automatic test_arst();
      logic [63:0] res;
      int          lat;
      i_op = 4'd0; i_src_1 = 64'd99; i_src_2 = 64'd77; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (30) begin @(posedge clk); #1; end
      arst = 1'b1;
      #2;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b want=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", o_valid); end
      checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL arst_result got=%h want=0", o_result); end
      @(posedge clk); #1;
      arst = 1'b0;
      do_op(4'd3, 64'h8000_0000_0000_0000, 64'd4, res, lat);
      checks++; if (res !== 64'd2) begin failures++; $display("FAIL arst_next_result got=%h want=2", res); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL arst_next_latency got=%0d want=65", lat); end
      ack();
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = pick_operand();
         b  = pick_operand();
         do_op(op, a, b, res, lat);
         checks++;
         if (res !== ref_result(op, a, b)) begin
            failures++;
            $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, ref_result(op, a, b));
         end
         checks++;
         if (lat !== ref_latency(op, a, b)) begin
            failures++;
            $display("FAIL rand_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat, ref_latency(op, a, b));
         end
         ack();
      end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_special();
      test_hold();
      test_flush();
      test_arst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "[TB] simulation did not terminate");
   end

endmodule
